// File: rtl/audio_sample_sink.sv
// -----------------------------------------------------------------------------
// audio_sample_sink
//
// Buffers unsigned 8-bit PCM samples from the flash fetch stage in a small
// FIFO and plays them out to a codec write port as signed OUT_WIDTH-bit
// samples. Playback first primes the FIFO to half full, then issues one
// single-cycle write strobe per audio_ready slot. If the FIFO runs dry, the
// last sample is repeated, the underrun counter is bumped and the sink
// re-primes.
//
// Ports
//   clk            : single clock for all logic
//   reset          : asynchronous, active-low reset
//   enable         : playback enable; 0 flushes the FIFO and returns to IDLE
//   mute           : output zero samples while still consuming the FIFO
//   sample_in      : unsigned 8-bit PCM sample
//   sample_valid   : sample_in is valid this cycle
//   sample_ready   : sink accepts a sample this cycle
//   audio_ready    : codec write FIFO can accept a sample
//   audio_write    : one-cycle write strobe to the codec
//   audio_left     : signed sample, left channel (registered)
//   audio_right    : signed sample, right channel, always equal to audio_left
//   fifo_level     : current FIFO occupancy
//   underrun_count : number of underrun events, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module audio_sample_sink #(
  parameter int DEPTH     = 8,   // power of two, >= 4
  parameter int OUT_WIDTH = 16   // >= 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mute,
  input  logic [7:0]               sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     audio_ready,
  output logic                     audio_write,
  output logic [OUT_WIDTH-1:0]     audio_left,
  output logic [OUT_WIDTH-1:0]     audio_right,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              underrun_count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  localparam lvl_t LVL_FULL = lvl_t'(DEPTH);
  localparam lvl_t LVL_HALF = lvl_t'(DEPTH / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  lvl_t                 level_q, level_d;
  logic                 write_q, write_d;
  logic [OUT_WIDTH-1:0] sample_q, sample_d;   // last written sample
  logic [15:0]          underrun_q, underrun_d;
  logic [7:0]           mem_q [DEPTH];

  logic push;
  logic slot;
  logic pop;
  logic underrun;

  // Offset-binary to two's complement: flip the MSB, left-justify.
  function automatic logic [OUT_WIDTH-1:0] to_signed(input logic [7:0] s);
    return {~s[7], s[6:0], {(OUT_WIDTH-8){1'b0}}};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and pop qualification
  // ---------------------------------------------------------------------------
  // sample_ready depends only on registered state and enable, never on
  // sample_valid or audio_ready. A full FIFO refuses a write even when a pop
  // happens in the same cycle.
  assign sample_ready = enable && (state_q != IDLE) && (level_q < LVL_FULL);
  assign push         = sample_valid && sample_ready;

  // A codec slot exists when the codec is ready and we did not write last
  // cycle; this keeps audio_write a single-cycle pulse.
  assign slot     = enable && (state_q == PLAY) && audio_ready && !write_q;
  assign pop      = slot && (level_q != '0);
  assign underrun = slot && (level_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    write_d    = 1'b0;
    sample_d   = sample_q;
    underrun_d = underrun_q;

    unique case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (level_q >= LVL_HALF) state_d = PLAY;
      PLAY:    if (underrun) state_d = PRIME;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    level_d = level_q + lvl_t'(push) - lvl_t'(pop);

    if (pop) begin
      write_d  = 1'b1;
      sample_d = mute ? '0 : to_signed(mem_q[rd_ptr_q]);
    end else if (underrun) begin
      // Repeat the previous output sample.
      write_d = 1'b1;
      if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
    end

    // Flush: drop contents, keep the counter and the last sample.
    if (!enable) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      write_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      write_q    <= 1'b0;
      sample_q   <= '0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      write_q    <= write_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the sample storage has no reset; zeroed pointers and level make its
  // contents unreachable, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign audio_write    = write_q;
  assign audio_left     = sample_q;
  assign audio_right    = sample_q;
  assign fifo_level     = level_q;
  assign underrun_count = underrun_q;

endmodule
